// File: rtl/execute_md_stage.sv
// Execute stage: registered ALU/branch ops plus an iterative multiply/divide unit with HI/LO.
// Optional macro FAST_MUL_EN: MULT/MULTU complete in one cycle through a combinational multiplier.
// Handshake: an op is taken when xs_i_valid && xs_o_ready && !xs_i_flush; xs_o_ready = !xs_o_busy.

module execute_md_stage #(
    parameter int DWIDTH    = 32,
    parameter int IMM_WIDTH = 16,
    parameter int PC_WIDTH  = 32,
    parameter int OP_WIDTH  = 5
) (
    input  logic                 xs_clk,
    input  logic                 xs_rst,
    input  logic                 xs_i_valid,
    input  logic                 xs_i_flush,
    input  logic [OP_WIDTH-1:0]  xs_i_op,
    input  logic                 xs_i_alu_src,
    input  logic [IMM_WIDTH-1:0] xs_i_imm,
    input  logic [PC_WIDTH-1:0]  xs_i_pc,
    input  logic [DWIDTH-1:0]    xs_i_data_rs,
    input  logic [DWIDTH-1:0]    xs_i_data_rt,
    output logic                 xs_o_ready,
    output logic                 xs_o_valid,
    output logic [OP_WIDTH-1:0]  xs_o_op,
    output logic [DWIDTH-1:0]    xs_o_result,
    output logic                 xs_o_zero,
    output logic                 xs_o_change_pc,
    output logic [PC_WIDTH-1:0]  xs_o_target_pc,
    output logic                 xs_o_busy
);
    localparam int SHW = $clog2(DWIDTH);

    localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_AND   = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_OR    = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_XOR   = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_SLT   = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SLTU  = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_SLL   = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_SRL   = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_SRA   = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(10);
    localparam logic [OP_WIDTH-1:0] OP_BNE   = OP_WIDTH'(11);
    localparam logic [OP_WIDTH-1:0] OP_MULT  = OP_WIDTH'(12);
    localparam logic [OP_WIDTH-1:0] OP_MULTU = OP_WIDTH'(13);
    localparam logic [OP_WIDTH-1:0] OP_DIV   = OP_WIDTH'(14);
    localparam logic [OP_WIDTH-1:0] OP_DIVU  = OP_WIDTH'(15);
    localparam logic [OP_WIDTH-1:0] OP_MFHI  = OP_WIDTH'(16);
    localparam logic [OP_WIDTH-1:0] OP_MFLO  = OP_WIDTH'(17);
    localparam logic [OP_WIDTH-1:0] OP_MTHI  = OP_WIDTH'(18);
    localparam logic [OP_WIDTH-1:0] OP_MTLO  = OP_WIDTH'(19);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MD_RUN = 2'd1, S_MD_DONE = 2'd2} state_e;

    state_e              state_q, state_d;
    logic [SHW-1:0]      cnt_q, cnt_d;
    logic [DWIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [DWIDTH-1:0]   md_hi_q, md_hi_d, md_lo_q, md_lo_d, md_b_q, md_b_d;
    logic [OP_WIDTH-1:0] md_op_q, md_op_d;
    logic                md_neg_q, md_neg_d, md_rneg_q, md_rneg_d, md_bzero_q, md_bzero_d;
    logic                valid_q, valid_d, zero_q, zero_d, change_pc_q, change_pc_d;
    logic [OP_WIDTH-1:0] op_q, op_d;
    logic [DWIDTH-1:0]   result_q, result_d;
    logic [PC_WIDTH-1:0] target_q, target_d;

    logic                busy, accept, br_taken;
    logic                is_mul, is_div, is_signed_md, is_iter, md_is_div, md_signed, div_ge;
    logic [DWIDTH-1:0]   imm_ext, op_b, alu_res, abs_a, abs_b, div_sub, md_quo, md_rem;
    logic [SHW-1:0]      shamt;
    logic [PC_WIDTH-1:0] br_target;
    logic [DWIDTH:0]     mul_sum, div_shift;
    logic [2*DWIDTH-1:0] md_prod;
`ifdef FAST_MUL_EN
    logic [2*DWIDTH-1:0] fast_prod;
`endif

    assign busy         = (state_q != S_IDLE);
    assign accept       = xs_i_valid && !busy && !xs_i_flush;
    assign imm_ext      = DWIDTH'($signed(xs_i_imm));
    assign op_b         = xs_i_alu_src ? imm_ext : xs_i_data_rt;
    assign shamt        = op_b[SHW-1:0];
    assign br_target    = xs_i_pc + (PC_WIDTH'($signed(xs_i_imm)) << 2);
    assign br_taken     = ((xs_i_op == OP_BEQ) && (xs_i_data_rs == xs_i_data_rt)) ||
                          ((xs_i_op == OP_BNE) && (xs_i_data_rs != xs_i_data_rt));
    assign is_mul       = (xs_i_op == OP_MULT) || (xs_i_op == OP_MULTU);
    assign is_div       = (xs_i_op == OP_DIV) || (xs_i_op == OP_DIVU);
    assign is_signed_md = (xs_i_op == OP_MULT) || (xs_i_op == OP_DIV);
`ifdef FAST_MUL_EN
    assign is_iter      = is_div;
    assign fast_prod    = is_signed_md ?
                          (2*DWIDTH)'($signed(xs_i_data_rs)) * (2*DWIDTH)'($signed(op_b)) :
                          {{DWIDTH{1'b0}}, xs_i_data_rs} * {{DWIDTH{1'b0}}, op_b};
`else
    assign is_iter      = is_mul || is_div;
`endif
    // The iterative core works on magnitudes; signs are restored in MD_DONE.
    assign abs_a = (is_signed_md && xs_i_data_rs[DWIDTH-1]) ? -xs_i_data_rs : xs_i_data_rs;
    assign abs_b = (is_signed_md && op_b[DWIDTH-1]) ? -op_b : op_b;

    assign md_is_div = (md_op_q == OP_DIV) || (md_op_q == OP_DIVU);
    assign md_signed = (md_op_q == OP_MULT) || (md_op_q == OP_DIV);
    assign mul_sum   = {1'b0, md_hi_q} + (md_lo_q[0] ? {1'b0, md_b_q} : '0);
    assign div_shift = {md_hi_q, md_lo_q[DWIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, md_b_q});
    assign div_sub   = div_shift[DWIDTH-1:0] - md_b_q;
    assign md_prod   = (md_signed && md_neg_q) ? -{md_hi_q, md_lo_q} : {md_hi_q, md_lo_q};
    // Divide-by-zero keeps the all-ones quotient regardless of operand signs.
    assign md_quo    = (md_signed && md_neg_q && !md_bzero_q) ? -md_lo_q : md_lo_q;
    assign md_rem    = (md_signed && md_rneg_q) ? -md_hi_q : md_hi_q;

    always_comb begin
        alu_res = '0;
        case (xs_i_op)
            OP_ADD:         alu_res = xs_i_data_rs + op_b;
            OP_SUB:         alu_res = xs_i_data_rs - op_b;
            OP_AND:         alu_res = xs_i_data_rs & op_b;
            OP_OR:          alu_res = xs_i_data_rs | op_b;
            OP_XOR:         alu_res = xs_i_data_rs ^ op_b;
            OP_SLT:         alu_res = DWIDTH'($signed(xs_i_data_rs) < $signed(op_b));
            OP_SLTU:        alu_res = DWIDTH'(xs_i_data_rs < op_b);
            OP_SLL:         alu_res = xs_i_data_rs << shamt;
            OP_SRL:         alu_res = xs_i_data_rs >> shamt;
            OP_SRA:         alu_res = $signed(xs_i_data_rs) >>> shamt;
            OP_BEQ, OP_BNE: alu_res = xs_i_data_rs - xs_i_data_rt;
            OP_MFHI:        alu_res = hi_q;
            OP_MFLO:        alu_res = lo_q;
            OP_MTHI,
            OP_MTLO:        alu_res = xs_i_data_rs;
            default:        alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        md_hi_d     = md_hi_q;
        md_lo_d     = md_lo_q;
        md_b_d      = md_b_q;
        md_op_d     = md_op_q;
        md_neg_d    = md_neg_q;
        md_rneg_d   = md_rneg_q;
        md_bzero_d  = md_bzero_q;
        valid_d     = 1'b0;
        change_pc_d = 1'b0;
        op_d        = op_q;
        result_d    = result_q;
        zero_d      = zero_q;
        target_d    = target_q;
        if (xs_i_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && is_iter) begin
                        md_hi_d    = '0;
                        md_lo_d    = abs_a;
                        md_b_d     = abs_b;
                        md_op_d    = xs_i_op;
                        md_neg_d   = is_signed_md && (xs_i_data_rs[DWIDTH-1] ^ op_b[DWIDTH-1]);
                        md_rneg_d  = is_signed_md && xs_i_data_rs[DWIDTH-1];
                        md_bzero_d = (op_b == '0);
                        cnt_d      = '0;
                        state_d    = S_MD_RUN;
                    end else if (accept) begin
                        valid_d     = 1'b1;
                        op_d        = xs_i_op;
                        result_d    = alu_res;
                        change_pc_d = br_taken;
                        target_d    = br_taken ? br_target : xs_i_pc;
                        if (xs_i_op == OP_MTHI) hi_d = xs_i_data_rs;
                        if (xs_i_op == OP_MTLO) lo_d = xs_i_data_rs;
`ifdef FAST_MUL_EN
                        if (is_mul) begin
                            hi_d     = fast_prod[2*DWIDTH-1:DWIDTH];
                            lo_d     = fast_prod[DWIDTH-1:0];
                            result_d = fast_prod[DWIDTH-1:0];
                        end
`endif
                        zero_d = (result_d == '0);
                    end
                end
                S_MD_RUN: begin
                    if (md_is_div) begin
                        md_hi_d = div_ge ? div_sub : div_shift[DWIDTH-1:0];
                        md_lo_d = {md_lo_q[DWIDTH-2:0], div_ge};
                    end else begin
                        md_hi_d = mul_sum[DWIDTH:1];
                        md_lo_d = {mul_sum[0], md_lo_q[DWIDTH-1:1]};
                    end
                    cnt_d = cnt_q + SHW'(1);
                    if (cnt_q == SHW'(DWIDTH - 1)) state_d = S_MD_DONE;
                end
                S_MD_DONE: begin
                    hi_d     = md_is_div ? md_rem : md_prod[2*DWIDTH-1:DWIDTH];
                    lo_d     = md_is_div ? md_quo : md_prod[DWIDTH-1:0];
                    valid_d  = 1'b1;
                    op_d     = md_op_q;
                    result_d = lo_d;
                    zero_d   = (lo_d == '0);
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge xs_clk) begin
        if (xs_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            md_hi_q     <= '0;
            md_lo_q     <= '0;
            md_b_q      <= '0;
            md_op_q     <= '0;
            md_neg_q    <= 1'b0;
            md_rneg_q   <= 1'b0;
            md_bzero_q  <= 1'b0;
            valid_q     <= 1'b0;
            change_pc_q <= 1'b0;
            op_q        <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            target_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            md_hi_q     <= md_hi_d;
            md_lo_q     <= md_lo_d;
            md_b_q      <= md_b_d;
            md_op_q     <= md_op_d;
            md_neg_q    <= md_neg_d;
            md_rneg_q   <= md_rneg_d;
            md_bzero_q  <= md_bzero_d;
            valid_q     <= valid_d;
            change_pc_q <= change_pc_d;
            op_q        <= op_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            target_q    <= target_d;
        end
    end

    assign xs_o_ready     = !busy;
    assign xs_o_busy      = busy;
    assign xs_o_valid     = valid_q;
    assign xs_o_op        = op_q;
    assign xs_o_result    = result_q;
    assign xs_o_zero      = zero_q;
    assign xs_o_change_pc = change_pc_q;
    assign xs_o_target_pc = target_q;

endmodule

// File: tb/tb_execute_md_stage.sv
// Bench for execute_md_stage: directed corner cases plus random ops against an arithmetic model of HI/LO and results.
// Honours FAST_MUL_EN when the same macro is defined for the bench.

module tb_execute_md_stage;
    localparam int W = 32;
`ifdef FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    logic          xs_clk, xs_rst, xs_i_valid, xs_i_flush, xs_i_alu_src;
    logic [4:0]    xs_i_op;
    logic [15:0]   xs_i_imm;
    logic [W-1:0]  xs_i_pc, xs_i_data_rs, xs_i_data_rt;
    logic          xs_o_ready, xs_o_valid, xs_o_zero, xs_o_change_pc, xs_o_busy;
    logic [4:0]    xs_o_op;
    logic [W-1:0]  xs_o_result, xs_o_target_pc;

    execute_md_stage dut (
        .xs_clk(xs_clk), .xs_rst(xs_rst), .xs_i_valid(xs_i_valid), .xs_i_flush(xs_i_flush),
        .xs_i_op(xs_i_op), .xs_i_alu_src(xs_i_alu_src), .xs_i_imm(xs_i_imm), .xs_i_pc(xs_i_pc),
        .xs_i_data_rs(xs_i_data_rs), .xs_i_data_rt(xs_i_data_rt), .xs_o_ready(xs_o_ready),
        .xs_o_valid(xs_o_valid), .xs_o_op(xs_o_op), .xs_o_result(xs_o_result), .xs_o_zero(xs_o_zero),
        .xs_o_change_pc(xs_o_change_pc), .xs_o_target_pc(xs_o_target_pc), .xs_o_busy(xs_o_busy)
    );

    // Clock and watchdog
    initial xs_clk = 1'b0;
    always #5 xs_clk = ~xs_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish before 5ms");
        $fatal(1, "watchdog");
    end

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] hi_m, lo_m;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge xs_clk);
        #1;
    endtask

    // Reference model: architectural meaning of each op, written with plain arithmetic.
    function automatic void model(input logic [4:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                                  input logic src, input logic [15:0] imm, input logic [W-1:0] pc,
                                  output logic [W-1:0] res, output logic chg, output logic [W-1:0] tgt);
        logic [W-1:0] b, sext;
        logic [63:0]  p;
        int           sh, a_s, b_s;
        sext = {{16{imm[15]}}, imm};
        b    = src ? sext : rt;
        sh   = int'(b[4:0]);
        a_s  = $signed(rs);
        b_s  = $signed(b);
        res  = '0;
        chg  = 1'b0;
        tgt  = pc;
        case (op)
            5'd0:  res = rs + b;
            5'd1:  res = rs - b;
            5'd2:  res = rs & b;
            5'd3:  res = rs | b;
            5'd4:  res = rs ^ b;
            5'd5:  res = (a_s < b_s) ? 32'd1 : 32'd0;
            5'd6:  res = (rs < b) ? 32'd1 : 32'd0;
            5'd7:  res = rs << sh;
            5'd8:  res = rs >> sh;
            5'd9:  res = $signed(rs) >>> sh;
            5'd10, 5'd11: begin
                res = rs - rt;
                chg = (op == 5'd10) ? (rs == rt) : (rs != rt);
                if (chg) tgt = pc + sext * 4;
            end
            5'd12: begin
                p = longint'(a_s) * longint'(b_s);
                hi_m = p[63:32]; lo_m = p[31:0]; res = lo_m;
            end
            5'd13: begin
                p = {32'd0, rs} * {32'd0, b};
                hi_m = p[63:32]; lo_m = p[31:0]; res = lo_m;
            end
            5'd14: begin
                if (b == 0) begin
                    lo_m = '1; hi_m = rs;
                end else if (rs == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo_m = 32'h8000_0000; hi_m = '0;
                end else begin
                    lo_m = a_s / b_s; hi_m = a_s % b_s;
                end
                res = lo_m;
            end
            5'd15: begin
                if (b == 0) begin
                    lo_m = '1; hi_m = rs;
                end else begin
                    lo_m = rs / b; hi_m = rs % b;
                end
                res = lo_m;
            end
            5'd16: res = hi_m;
            5'd17: res = lo_m;
            5'd18: begin hi_m = rs; res = rs; end
            5'd19: begin lo_m = rs; res = rs; end
            default: res = '0;
        endcase
    endfunction

    // Driver: present one op, wait for its result, check it and the following idle cycle.
    task automatic run_op(input logic [4:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                          input logic src, input logic [15:0] imm, input logic [W-1:0] pc, input bit poke);
        logic [W-1:0] e_res, e_tgt, e;
        logic         e_chg;
        bit           iter;
        int           n, bad;
        model(op, rs, rt, src, imm, pc, e_res, e_chg, e_tgt);
        exp_q.push_back(e_res);
        iter = (op == 5'd14 || op == 5'd15) || (!FAST_MUL && (op == 5'd12 || op == 5'd13));
        check("ready_before_op", xs_o_ready, 1);
        xs_i_valid = 1'b1; xs_i_op = op; xs_i_data_rs = rs; xs_i_data_rt = rt;
        xs_i_alu_src = src; xs_i_imm = imm; xs_i_pc = pc;
        step();
        if (iter) begin
            if (poke) begin
                xs_i_op = 5'd0; xs_i_data_rs = 32'd1; xs_i_data_rt = 32'd1;
            end else begin
                xs_i_valid = 1'b0;
            end
            n = 0; bad = 0;
            while (!xs_o_valid && n < W + 8) begin
                if (!xs_o_busy || xs_o_ready) bad++;
                step();
                n++;
            end
            xs_i_valid = 1'b0;
            check("md_busy_not_ready_cycles", bad, 0);
            check("md_latency", n + 1, W + 2);
        end else begin
            xs_i_valid = 1'b0;
        end
        e = exp_q.pop_front();
        check("valid", xs_o_valid, 1);
        check("result", xs_o_result, e);
        check("zero", xs_o_zero, (e == 0));
        check("op", xs_o_op, op);
        check("change_pc", xs_o_change_pc, iter ? 1'b0 : e_chg);
        if (!iter) check("target_pc", xs_o_target_pc, e_tgt);
        step();
        check("valid_clears", xs_o_valid, 0);
        check("change_pc_clears", xs_o_change_pc, 0);
        check("result_holds", xs_o_result, e);
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, xs_o_valid, 0);
        check({tag, "_result"}, xs_o_result, 0);
        check({tag, "_zero"}, xs_o_zero, 0);
        check({tag, "_change_pc"}, xs_o_change_pc, 0);
        check({tag, "_target"}, xs_o_target_pc, 0);
        check({tag, "_op"}, xs_o_op, 0);
        check({tag, "_busy"}, xs_o_busy, 0);
        check({tag, "_ready"}, xs_o_ready, 1);
    endtask

    initial begin
        logic [4:0] rop, fl_op;
        logic       rsrc;
        int         vcount;
        xs_rst = 1'b1; xs_i_valid = 1'b0; xs_i_flush = 1'b0; xs_i_op = '0; xs_i_alu_src = 1'b0;
        xs_i_imm = '0; xs_i_pc = '0; xs_i_data_rs = '0; xs_i_data_rt = '0;
        hi_m = '0; lo_m = '0;
        repeat (2) step();
        xs_rst = 1'b0;
        check_reset_outputs("por");

        // Reset held 2 cycles in the middle of a DIV
        run_op(5'd18, 32'h1234, 0, 0, 0, 0, 0);
        xs_i_valid = 1'b1; xs_i_op = 5'd14; xs_i_data_rs = 32'd100; xs_i_data_rt = 32'd7; xs_i_alu_src = 1'b0;
        step();
        xs_i_valid = 1'b0;
        repeat (5) step();
        check("div_busy_before_reset", xs_o_busy, 1);
        xs_rst = 1'b1;
        repeat (2) step();
        xs_rst = 1'b0;
        hi_m = '0; lo_m = '0;
        check_reset_outputs("mid_div_reset");
        run_op(5'd16, 0, 0, 0, 0, 0, 0);

        // ALU wrap and zero flag
        run_op(5'd0, 32'h7FFF_FFFF, 32'd1, 0, 0, 32'h40, 0);
        run_op(5'd1, 32'd5, 32'd5, 0, 0, 32'h44, 0);

        // Branches
        run_op(5'd10, 32'd3, 32'd3, 0, 16'hFFFE, 32'h100, 0);
        run_op(5'd11, 32'd3, 32'd3, 0, 16'hFFFE, 32'h100, 0);

        // Signed multiply while an ADD is presented during the busy period
        run_op(5'd12, 32'hFFFF_FFFD, 32'd7, 0, 0, 0, 1);
        run_op(5'd16, 0, 0, 0, 0, 0, 0);

        // Divide corner cases
        run_op(5'd15, 32'd100, 32'd0, 0, 0, 0, 0);
        run_op(5'd16, 0, 0, 0, 0, 0, 0);
        run_op(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
        run_op(5'd16, 0, 0, 0, 0, 0, 0);
        run_op(5'd14, 32'hFFFF_FFFB, 32'd0, 0, 0, 0, 0);
        run_op(5'd17, 0, 0, 0, 0, 0, 0);

        // Flush in cycle 10 of a multi-cycle op
        fl_op = FAST_MUL ? 5'd15 : 5'd13;
        run_op(5'd18, 32'h55, 0, 0, 0, 0, 0);
        xs_i_valid = 1'b1; xs_i_op = fl_op; xs_i_data_rs = 32'd1234; xs_i_data_rt = 32'd77; xs_i_alu_src = 1'b0;
        step();
        xs_i_valid = 1'b0;
        repeat (9) step();
        xs_i_flush = 1'b1;
        step();
        xs_i_flush = 1'b0;
        check("flush_busy", xs_o_busy, 0);
        check("flush_ready", xs_o_ready, 1);
        vcount = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (xs_o_valid) vcount++;
            step();
        end
        check("flush_no_valid_pulses", vcount, 0);
        run_op(5'd16, 0, 0, 0, 0, 0, 0);

        // Flush together with a presented ADD
        xs_i_valid = 1'b1; xs_i_op = 5'd0; xs_i_data_rs = 32'd1; xs_i_data_rt = 32'd2; xs_i_flush = 1'b1;
        step();
        xs_i_valid = 1'b0; xs_i_flush = 1'b0;
        check("flush_add_valid", xs_o_valid, 0);
        check("flush_add_result_hold", xs_o_result, hi_m);
        step();
        check("flush_add_valid_late", xs_o_valid, 0);

        // Random ops
        for (int i = 0; i < 150; i++) begin
            rop  = 5'($urandom_range(0, 31));
            rsrc = (rop >= 5'd12 && rop <= 5'd15) ? 1'b0 : 1'($urandom_range(0, 1));
            run_op(rop, rnd_val(), rnd_val(), rsrc, 16'($urandom()), {$urandom(), 2'b00} >> 2 << 2, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
